// File: rtl/muldiv_arbiter_if.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter_if
//   Bundles the requester-side and unit-side handshake signals of the
//   multiply/divide arbiter.
//
//   Requester n (0 = main context, 1 = interrupt context):
//     reqn_valid / reqn_op / reqn_mode / reqn_a / reqn_b  -> arbiter
//     reqn_ready / rspn_valid / rspn_data / rspn_dbz      <- arbiter
//   Shared arithmetic unit:
//     u_start / u_op / u_mode / u_a / u_b                 <- arbiter
//     u_done / u_res                                      -> arbiter
//
//   Modports:
//     slave  : the arbiter itself
//     master : the environment (requesters plus the arithmetic unit)
// -----------------------------------------------------------------------------
interface muldiv_arbiter_if;
  // Requester 0
  logic        req0_valid;
  logic [1:0]  req0_op;
  logic        req0_mode;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [15:0] rsp0_data;
  logic        rsp0_dbz;

  // Requester 1
  logic        req1_valid;
  logic [1:0]  req1_op;
  logic        req1_mode;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [15:0] rsp1_data;
  logic        rsp1_dbz;

  // Arithmetic unit
  logic        u_start;
  logic [1:0]  u_op;
  logic        u_mode;
  logic [15:0] u_a;
  logic [15:0] u_b;
  logic        u_done;
  logic [15:0] u_res;

  modport slave (
    input  req0_valid, req0_op, req0_mode, req0_a, req0_b,
    input  req1_valid, req1_op, req1_mode, req1_a, req1_b,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_dbz,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_dbz,
    output u_start, u_op, u_mode, u_a, u_b,
    input  u_done, u_res
  );

  modport master (
    output req0_valid, req0_op, req0_mode, req0_a, req0_b,
    output req1_valid, req1_op, req1_mode, req1_a, req1_b,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_dbz,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_dbz,
    input  u_start, u_op, u_mode, u_a, u_b,
    output u_done, u_res
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter
//   Shares one multi-cycle shift/multiply/divide unit between a main-context
//   requester (0) and an interrupt-context requester (1). Requester 1 wins
//   contention, but after STARVE_MAX consecutive wins while requester 0 is
//   waiting, requester 0 is served once. Divide-by-zero is resolved locally
//   without starting the unit (result 16'hFFFF, dbz = 1).
//
//   One transaction at a time:
//     IDLE  : grant a requester (ready pulse), latch its operands
//     ISSUE : pulse u_start (or short-circuit a divide-by-zero)
//     WAIT  : hold operands on the unit until u_done
//     RESP  : pulse rspn_valid to the granted requester
//
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous, active-high reset
//     bus  : muldiv_arbiter_if.slave (requester and unit handshakes)
//   Parameters:
//     STARVE_MAX : max consecutive requester-1 grants while requester 0 waits
//                  (must fit in 3 bits)
// -----------------------------------------------------------------------------
module muldiv_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  muldiv_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_DIV   = 2'b10;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,     state_d;
  logic        gnt_q,       gnt_d;       // 0 = requester 0, 1 = requester 1
  logic [1:0]  op_q,        op_d;
  logic        mode_q,      mode_d;
  logic [15:0] a_q,         a_d;
  logic [15:0] b_q,         b_d;
  logic [2:0]  starve_q,    starve_d;
  logic [15:0] rsp0_data_q, rsp0_data_d;
  logic        rsp0_dbz_q,  rsp0_dbz_d;
  logic [15:0] rsp1_data_q, rsp1_data_d;
  logic        rsp1_dbz_q,  rsp1_dbz_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic in_idle;
  logic grant_any;
  logic grant_id;
  logic latched_dbz;
  logic result_wr;
  logic [15:0] result_data;
  logic        result_dbz;

  assign in_idle     = (state_q == ST_IDLE);
  assign grant_any   = in_idle && (bus.req0_valid || bus.req1_valid);
  assign latched_dbz = (op_q == OP_DIV) && (b_q == 16'h0000);

  // Requester 1 wins unless requester 0 has already been passed over
  // STARVE_MAX times in a row.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = (starve_q == STARVE_LIM) ? 1'b0 : 1'b1;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  // A result is produced either by the local divide-by-zero short-circuit or
  // by the unit completing while we wait for it.
  always_comb begin
    result_wr   = 1'b0;
    result_data = 16'h0000;
    result_dbz  = 1'b0;
    if (state_q == ST_ISSUE && latched_dbz) begin
      result_wr   = 1'b1;
      result_data = 16'hFFFF;
      result_dbz  = 1'b1;
    end else if (state_q == ST_WAIT && bus.u_done) begin
      result_wr   = 1'b1;
      result_data = bus.u_res;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    starve_d    = starve_q;
    rsp0_data_d = rsp0_data_q;
    rsp0_dbz_d  = rsp0_dbz_q;
    rsp1_data_d = rsp1_data_q;
    rsp1_dbz_d  = rsp1_dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ISSUE;
          gnt_d   = grant_id;
          op_d    = grant_id ? bus.req1_op   : bus.req0_op;
          mode_d  = grant_id ? bus.req1_mode : bus.req0_mode;
          a_d     = grant_id ? bus.req1_a    : bus.req0_a;
          b_d     = grant_id ? bus.req1_b    : bus.req0_b;
        end
      end
      ST_ISSUE: state_d = latched_dbz ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (bus.u_done) state_d = ST_RESP;
      default:  state_d = ST_IDLE;   // ST_RESP: one-cycle response pulse
    endcase

    // Starvation counter only moves on IDLE cycles. When requester 0 is not
    // asking, there is nobody being starved, so the count restarts.
    if (in_idle) begin
      if (!bus.req0_valid || (grant_any && !grant_id)) begin
        starve_d = 3'd0;
      end else if (grant_any && grant_id && starve_q != STARVE_LIM) begin
        starve_d = starve_q + 3'd1;
      end
    end

    // Response data is registered per requester so each one keeps its last
    // result until it is served again.
    if (result_wr) begin
      if (gnt_q) begin
        rsp1_data_d = result_data;
        rsp1_dbz_d  = result_dbz;
      end else begin
        rsp0_data_d = result_data;
        rsp0_dbz_d  = result_dbz;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the latched request and held response data are reset too, because
  // both are visible on outputs and must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      op_q        <= 2'b00;
      mode_q      <= 1'b0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      starve_q    <= 3'd0;
      rsp0_data_q <= 16'h0000;
      rsp0_dbz_q  <= 1'b0;
      rsp1_data_q <= 16'h0000;
      rsp1_dbz_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      starve_q    <= starve_d;
      rsp0_data_q <= rsp0_data_d;
      rsp0_dbz_q  <= rsp0_dbz_d;
      rsp1_data_q <= rsp1_data_d;
      rsp1_dbz_q  <= rsp1_dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic drive_unit;

  // Operands stay on the unit bus from ISSUE through WAIT and read 0 elsewhere,
  // so a unit that samples late still sees the granted operands.
  assign drive_unit = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any &&  grant_id;

  assign bus.u_start = (state_q == ST_ISSUE) && !latched_dbz;
  assign bus.u_op    = drive_unit ? op_q   : 2'b00;
  assign bus.u_mode  = drive_unit ? mode_q : 1'b0;
  assign bus.u_a     = drive_unit ? a_q    : 16'h0000;
  assign bus.u_b     = drive_unit ? b_q    : 16'h0000;

  assign bus.rsp0_valid = (state_q == ST_RESP) && !gnt_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) &&  gnt_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp0_dbz   = rsp0_dbz_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.rsp1_dbz   = rsp1_dbz_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_arbiter
//   Directed-vector bench for muldiv_arbiter. Stimulus tasks push the expected
//   response per requester into a queue; a monitor pops and compares whenever
//   the DUT pulses rspn_valid. A behavioural arithmetic unit answers u_start
//   after a programmable latency and watches operand stability.
// -----------------------------------------------------------------------------
module tb_muldiv_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_arbiter_if bus ();

  muldiv_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        dbz;
  } rsp_t;

  rsp_t exp0_q[$];
  rsp_t exp1_q[$];
  int   grant_log[$];
  int   grant_cyc[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int ustart_cyc = -1, ustart_cnt = 0, done_cyc = -1;
  int rsp0_cyc = -1, rsp1_cyc = -1;

  // Unit-model controls and observations
  int          unit_lat  = 3;
  bit          unit_en   = 1'b1;
  bit          spur_req  = 1'b0;
  logic [15:0] spur_res  = 16'h0000;
  bit          hold_ok   = 1'b1;
  logic [1:0]  c_op;
  logic        c_mode;
  logic [15:0] c_a, c_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] unit_model(input logic [1:0] op, input logic mode,
                                             input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a << b[3:0];
      2'b01:   return a * b;
      2'b10:   return mode ? 16'($signed(a) / $signed(b)) : a / b;
      default: return mode ? 16'($signed(a) >>> b[3:0]) : a >> b[3:0];
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Arithmetic unit model: sole driver of u_done / u_res
  // ---------------------------------------------------------------------------
  initial begin
    int  cnt;
    bit  watch;
    cnt   = 0;
    watch = 1'b0;
    bus.u_done = 1'b0;
    bus.u_res  = 16'h0000;
    forever begin
      @(negedge clk);
      if (watch && {bus.u_op, bus.u_mode, bus.u_a, bus.u_b} !== {c_op, c_mode, c_a, c_b})
        hold_ok = 1'b0;
      if (unit_en && bus.u_start && cnt == 0) begin
        c_op    = bus.u_op;
        c_mode  = bus.u_mode;
        c_a     = bus.u_a;
        c_b     = bus.u_b;
        hold_ok = 1'b1;
        watch   = 1'b1;
        cnt     = unit_lat;
      end
      @(posedge clk);
      #1;
      if (bus.u_done) watch = 1'b0;
      bus.u_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.u_done = 1'b1;
          bus.u_res  = unit_model(c_op, c_mode, c_a, c_b);
        end
      end
      if (spur_req) begin
        bus.u_done = 1'b1;
        bus.u_res  = spur_res;
        spur_req   = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.u_start) begin
        ustart_cyc = cyc;
        ustart_cnt++;
      end
      if (bus.u_done) done_cyc = cyc;
      if (bus.req0_ready || bus.req1_ready) begin
        check("ready_onehot", 32'(bus.req0_ready && bus.req1_ready), 0);
        grant_log.push_back(bus.req1_ready ? 1 : 0);
        grant_cyc.push_back(cyc);
      end
      if (bus.rsp0_valid) begin
        rsp0_cyc = cyc;
        if (exp0_q.size() == 0) check("rsp0_unexpected", 1, 0);
        else begin
          e = exp0_q.pop_front();
          check("rsp0_data", bus.rsp0_data, e.data);
          check("rsp0_dbz", bus.rsp0_dbz, e.dbz);
        end
      end
      if (bus.rsp1_valid) begin
        rsp1_cyc = cyc;
        if (exp1_q.size() == 0) check("rsp1_unexpected", 1, 0);
        else begin
          e = exp1_q.pop_front();
          check("rsp1_data", bus.rsp1_data, e.data);
          check("rsp1_dbz", bus.rsp1_dbz, e.dbz);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (call at posedge + #1; return at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic issue(input int n, input logic [1:0] op, input logic mode,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_data, input logic exp_dbz,
                       input bit push, output int gcyc);
    rsp_t e;
    bit   got;
    got    = 1'b0;
    gcyc   = -1;
    e.data = exp_data;
    e.dbz  = exp_dbz;
    if (push) begin
      if (n == 0) exp0_q.push_back(e);
      else        exp1_q.push_back(e);
    end
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_mode = mode; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_mode = mode; bus.req1_a = a; bus.req1_b = b;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) check((n == 0) ? "req0_ready_timeout" : "req1_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && i < 300) begin
      @(posedge clk);
      i++;
    end
    check("drain_timeout", 32'(exp0_q.size() + exp1_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                     bus.rsp0_dbz, bus.rsp1_dbz, bus.u_start, bus.u_mode, bus.u_op}), 0);
    check({name, "_rsp_data"}, {bus.rsp0_data, bus.rsp1_data}, 0);
    check({name, "_u_ab"}, {bus.u_a, bus.u_b}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  op;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  initial begin
    int   g, c, s0;
    vec_t tbl[5];
    int   exp_order[10];

    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_mode = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_mode = 1'b0; bus.req1_a = '0; bus.req1_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single multiply, unit answers 3 cycles after u_start; served at once
    unit_lat = 3;
    c = cyc;
    issue(0, 2'b01, 1'b0, 16'd7, 16'd6, 16'd42, 1'b0, 1'b1, g);
    drain();
    check("mul_grant_first_idle", g, c);
    check("mul_ustart_lat", ustart_cyc, g + 1);
    check("mul_done_lat", done_cyc, ustart_cyc + 3);
    check("mul_rsp_lat", rsp0_cyc, done_cyc + 1);

    // Divide by zero on requester 1: no u_start, response at T+2
    s0 = ustart_cnt;
    issue(1, 2'b10, 1'b0, 16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b1, g);
    drain();
    check("dbz_no_ustart", ustart_cnt, s0);
    check("dbz_rsp_lat", rsp1_cyc, g + 2);

    // Assorted ops, signed and unsigned, single-cycle unit
    unit_lat = 1;
    tbl[0] = '{2'b00, 1'b0, 16'h0003, 16'h0004, 16'h0030};  // 3 << 4
    tbl[1] = '{2'b01, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA};  // -2 * 3
    tbl[2] = '{2'b10, 1'b1, 16'hFF9C, 16'h0007, 16'hFFF2};  // -100 / 7
    tbl[3] = '{2'b10, 1'b0, 16'd100,  16'd7,    16'h000E};  // 100 / 7
    tbl[4] = '{2'b11, 1'b1, 16'h8000, 16'h0004, 16'hF800};  // arith >> 4
    for (int i = 0; i < 5; i++) begin
      issue(i % 2, tbl[i].op, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].res, 1'b0, 1'b1, g);
      drain();
    end

    // Shift pass-through with operand hold over a 4-cycle unit
    unit_lat = 4;
    issue(0, 2'b11, 1'b0, 16'h8000, 16'h0003, 16'h1000, 1'b0, 1'b1, g);
    drain();
    check("shr_hold_stable", hold_ok, 1);
    check("shr_u_op", c_op, 2'b11);
    check("shr_u_ab", {c_a, c_b}, 32'h8000_0003);
    @(negedge clk);
    check("idle_unit_bus_zero", {14'd0, bus.u_op, bus.u_a}, 0);
    @(posedge clk); #1;

    // Contention: both valid continuously, unit answers in 2 cycles
    unit_lat = 2;
    grant_log.delete();
    grant_cyc.delete();
    fork
      begin : req0_side
        int g0;
        for (int k = 0; k < 2; k++)
          issue(0, 2'b00, 1'b0, 16'h0001, 16'(k + 1), 16'(1 << (k + 1)), 1'b0, 1'b1, g0);
      end
      begin : req1_side
        int g1;
        for (int k = 0; k < 8; k++)
          issue(1, 2'b01, 1'b0, 16'(k + 2), 16'd5, 16'((k + 2) * 5), 1'b0, 1'b1, g1);
      end
    join
    drain();
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    check("contention_grant_count", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);
    for (int i = 1; i < grant_cyc.size(); i++)
      check($sformatf("grant_gap_%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1] >= 5), 1);

    // Reset during WAIT, stale u_done one cycle after release
    unit_en = 1'b0;
    issue(0, 2'b01, 1'b0, 16'd5, 16'd5, 16'd0, 1'b0, 1'b0, g);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_in_wait", {bus.u_start, bus.u_op}, 3'b001);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    spur_res = 16'h1234;
    spur_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("after_reset");
    end
    unit_en = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    issue(0, 2'b01, 1'b1, 16'hFFFD, 16'h0004, 16'hFFF4, 1'b0, 1'b1, g);
    drain();
    check("post_reset_grant", g, c);

    // Spurious u_done in IDLE
    @(negedge clk);
    spur_res = 16'hBEEF;
    spur_req = 1'b1;
    @(negedge clk);
    check("spur_no_activity",
          32'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.u_start}), 0);
    @(posedge clk); #1;
    c = cyc;
    issue(1, 2'b00, 1'b0, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b1, g);
    drain();
    check("spur_then_grant", g, c);
    check("rsp0_held", bus.rsp0_data, 16'hFFF4);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL provide: clk  input  1  clock; all state on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide, for each requester n in {0 = main context, 1 = interrupt context}: reqn_valid input 1; reqn_op input 2 (00 shl, 01 mul, 10 div, 11 shr); reqn_mode input 1 (signed when 1); reqn_a input 16; reqn_b input 16.
REQ-004 SHALL provide, for each requester n, these outputs: reqn_ready 1 (accept pulse); rspn_valid 1 (result pulse); rspn_data 16 (result); rspn_dbz 1 (divide-by-zero flag).
REQ-005 SHALL provide these unit-side outputs: u_start 1; u_op 2; u_mode 1; u_a 16; u_b 16.
REQ-006 SHALL provide these unit-side inputs: u_done 1 (one-cycle completion pulse); u_res 16 (valid with u_done).
REQ-007 SHALL provide a parameter STARVE_MAX, default 4: maximum consecutive requester-1 grants while requester 0 waits.

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-009 SHALL, in IDLE with any reqn_valid high, grant one requester: pulse reqn_ready for that cycle, latch op/mode/a/b plus grant id, go to ISSUE.
REQ-010 SHALL grant requester 1 when both valid, unless starve counter == STARVE_MAX, then grant requester 0.
REQ-011 SHALL use a 3-bit starve counter: +1 on each grant to requester 1 while req0_valid high; clear on grant to requester 0 or when req0_valid low in IDLE; saturate at STARVE_MAX.
REQ-012 SHALL, in ISSUE with latched op == 10 and latched b == 0: keep u_start low, go to RESP with result 16'hFFFF and dbz = 1.
REQ-013 SHALL, in ISSUE otherwise: pulse u_start for exactly one cycle, driving latched values on u_op/u_mode/u_a/u_b, go to WAIT.
REQ-014 SHALL hold u_op/u_mode/u_a/u_b stable from ISSUE until leaving WAIT; drive them 0 in IDLE.
REQ-015 SHALL, in WAIT on u_done: capture u_res with dbz = 0, go to RESP.
REQ-016 SHALL ignore u_done in IDLE, ISSUE and RESP.
REQ-017 SHALL, in RESP: pulse rspn_valid for the granted requester only, drive rspn_data/rspn_dbz, go to IDLE.
REQ-018 SHALL hold rspn_data/rspn_dbz until the next response to that requester.
REQ-019 SHALL NOT grant a new request in RESP; back-to-back grant is earliest the cycle after RESP.
REQ-020 SHALL give latency from grant cycle T: u_start at T+1; u_done at cycle D gives rspn_valid at D+1. Divide-by-zero gives rspn_valid at T+2.
REQ-021 SHALL keep reqn_ready low outside IDLE; a requester holds valid and operands until its ready pulse.
REQ-022 SHALL NOT time out in WAIT; it waits for u_done indefinitely.

Reset
REQ-023 SHALL, on rst (any time, including mid-WAIT), go to IDLE and clear the starve counter, latched request, and all outputs to 0; an in-flight unit result is discarded.
REQ-024 SHALL, after rst release, accept requests the first clock edge at which it is in IDLE.

Verification
REQ-025 Single mul: req0 op=01 a=7 b=6, u_done 3 cycles after u_start with u_res=42 -> req0_ready at T, u_start at T+1, rsp0_valid with data 42, dbz 0 one cycle after u_done; rsp1_valid stays 0.
REQ-026 Div by zero: req1 op=10 a=100 b=0 -> u_start never asserts; rsp1_valid at T+2 with data FFFF, dbz 1.
REQ-027 Contention: both valid continuously, unit returns in 2 cycles -> grant order 1,1,1,1,0,1,1,1,1,0; no two grants closer than 5 cycles.
REQ-028 Reset mid-op: rst pulsed during WAIT, stale u_done one cycle after release -> no rsp pulse; all outputs 0; next request served normally.
REQ-029 Spurious done: u_done pulses in IDLE with no request -> state stays IDLE, no rsp, ready unaffected.
REQ-030 Shift pass-through: req0 op=11 mode=0 a=8000 b=3 -> u_op=11, u_a=8000, u_b=0003 stable from u_start until u_done; rsp0_data equals u_res.
